nexys_starship_spawn_sched: RTL and testbench

Monster spawn scheduler for Nexys Starship. It decides when a new monster appears and in which of the four slots (top, bottom, left, right). It drives the per-slot spawn requests consumed by the slot state machines, and it raises the spawn rate as the game progresses. It sits between the game-level play/gameover control and the four monster-slot controllers, and it is the only source of their spawn inputs.

---
 rtl/nexys_starship_spawn_sched_pkg.sv | 31 +++
 rtl/nexys_starship_lfsr8.sv | 24 ++
 rtl/nexys_starship_spawn_sched.sv | 132 +++++++++++++
 tb/tb_nexys_starship_spawn_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/nexys_starship_spawn_sched_pkg.sv
// Shared definitions for the Nexys Starship monster spawn scheduler: slot indices,
// state encodings, the spawn interval table and the default LFSR seed.
package nexys_starship_spawn_sched_pkg;

   localparam logic [1:0] TOP    = 2'd0;
   localparam logic [1:0] BOTTOM = 2'd1;
   localparam logic [1:0] LEFT   = 2'd2;
   localparam logic [1:0] RIGHT  = 2'd3;

   localparam logic [7:0] DEFAULT_SEED = 8'hA5;

   typedef enum logic [2:0] {
      INIT = 3'b001,
      RUN  = 3'b010,
      HOLD = 3'b100
   } state_t;

   // Ticks between spawn attempts; higher levels spawn faster.
   function automatic logic [2:0] spawn_interval(input logic [1:0] lvl);
      logic [2:0] ticks;
      ticks = 3'd4;
      case (lvl)
         2'd0:    ticks = 3'd4;
         2'd1:    ticks = 3'd3;
         2'd2:    ticks = 3'd2;
         default: ticks = 3'd1;
      endcase
      return ticks;
   endfunction

endpackage

// File: rtl/nexys_starship_lfsr8.sv
// 8-bit Fibonacci LFSR used to pick the preferred spawn slot.
module nexys_starship_lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       load,
   input  logic       enable,
   output logic [1:0] cand
);

   logic [7:0] value;

   always_ff @(posedge Clk) begin
      if (Reset || load) begin
         value <= SEED;
      end else if (enable) begin
         value <= {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
      end
   end

   assign cand = value[1:0];

endmodule

// File: rtl/nexys_starship_spawn_sched.sv
// Monster spawn scheduler: paces spawn attempts by difficulty level and picks a free
// slot starting from a pseudo-random candidate, retrying while all slots are busy.
module nexys_starship_spawn_sched
   import nexys_starship_spawn_sched_pkg::*;
#(
   parameter logic [7:0]  SEED         = DEFAULT_SEED,
   parameter int unsigned LEVEL_SPAWNS = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       play_flag,
   input  logic       tick,
   input  logic       gameover_in,
   input  logic [3:0] occupied,
   output logic [3:0] spawn,
   output logic [1:0] level,
   output logic [7:0] spawn_count,
   output logic       q_Init,
   output logic       q_Run,
   output logic       q_Hold
);

   state_t      state;
   logic [2:0]  tick_cnt;
   logic        pending;
   logic [1:0]  lfsr_cand;
   logic [2:0]  interval;
   logic        attempt;
   logic        found;
   logic [1:0]  sel;
   logic [1:0]  probe;
   logic [3:0]  sel_onehot;
   logic [1:0]  level_nxt;
   int unsigned level_raw;

   nexys_starship_lfsr8 #(
      .SEED (SEED)
   ) u_lfsr (
      .Clk    (Clk),
      .Reset  (Reset),
      .load   ((state == INIT) && play_flag),
      .enable (state == RUN),
      .cand   (lfsr_cand)
   );

   assign interval = spawn_interval(level);
   assign attempt  = (state == RUN) && tick && !gameover_in && ((tick_cnt + 3'd1) == interval);

   // Probe candidate, candidate+1, +2, +3 (mod 4); first free slot wins.
   always_comb begin
      found = 1'b0;
      sel   = lfsr_cand;
      probe = lfsr_cand;
      for (int i = 0; i < 4; i++) begin
         probe = lfsr_cand + 2'(i);
         if (!found && !occupied[probe]) begin
            found = 1'b1;
            sel   = probe;
         end
      end
   end

   always_comb begin
      sel_onehot = 4'b0000;
      case (sel)
         TOP:     sel_onehot = 4'b0001;
         BOTTOM:  sel_onehot = 4'b0010;
         LEFT:    sel_onehot = 4'b0100;
         RIGHT:   sel_onehot = 4'b1000;
         default: sel_onehot = 4'b0000;
      endcase
   end

   always_comb begin
      level_raw = 32'(spawn_count) / LEVEL_SPAWNS;
      level_nxt = (level_raw > 32'd2) ? 2'd3 : level_raw[1:0];
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= INIT;
         tick_cnt    <= 3'd0;
         pending     <= 1'b0;
         spawn       <= 4'b0000;
         spawn_count <= 8'd0;
         level       <= 2'd0;
      end else begin
         spawn <= 4'b0000;
         level <= level_nxt;
         case (state)
            INIT: begin
               tick_cnt    <= 3'd0;
               pending     <= 1'b0;
               spawn_count <= 8'd0;
               if (play_flag) state <= RUN;
            end
            RUN: begin
               if (gameover_in) begin
                  state   <= HOLD;
                  pending <= 1'b0;
               end else begin
                  if (tick) tick_cnt <= attempt ? 3'd0 : tick_cnt + 3'd1;
                  // A fresh attempt while already pending just merges into the retry.
                  if (attempt || pending) begin
                     if (found) begin
                        spawn   <= sel_onehot;
                        pending <= 1'b0;
                        if (spawn_count != 8'hFF) spawn_count <= spawn_count + 8'd1;
                     end else begin
                        pending <= 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               if (!play_flag) begin
                  state       <= INIT;
                  tick_cnt    <= 3'd0;
                  pending     <= 1'b0;
                  spawn_count <= 8'd0;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   assign q_Init = (state == INIT);
   assign q_Run  = (state == RUN);
   assign q_Hold = (state == HOLD);

endmodule

// File: tb/tb_nexys_starship_spawn_sched.sv
// Directed bench for the spawn scheduler with hand-derived expectations.
module tb_nexys_starship_spawn_sched;
   import nexys_starship_spawn_sched_pkg::*;

   localparam logic [7:0] SEED_TB = 8'hA5;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       play_flag;
   logic       tick;
   logic       gameover_in;
   logic [3:0] occupied;
   logic [3:0] spawn;
   logic [1:0] level;
   logic [7:0] spawn_count;
   logic       q_Init, q_Run, q_Hold;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_lfsr = SEED_TB;
   bit         m_run = 1'b0;
   logic [3:0] exp_spawn;
   logic [3:0] first_exp;

   nexys_starship_spawn_sched #(
      .SEED         (SEED_TB),
      .LEVEL_SPAWNS (16)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .play_flag   (play_flag),
      .tick        (tick),
      .gameover_in (gameover_in),
      .occupied    (occupied),
      .spawn       (spawn),
      .level       (level),
      .spawn_count (spawn_count),
      .q_Init      (q_Init),
      .q_Run       (q_Run),
      .q_Hold      (q_Hold)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic step();
      @(posedge Clk);
      if (m_run) m_lfsr = lfsr_next(m_lfsr);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Nine idle cycles then a one-cycle tick; the tick cycle's LFSR picks the candidate.
   task automatic tick_once();
      tick = 1'b0;
      repeat (9) step();
      tick = 1'b1;
      exp_spawn = 4'b0001 << m_lfsr[1:0];
      step();
      tick = 1'b0;
   endtask

   task automatic run_ticks(input int n);
      tick = 1'b1;
      repeat (n) step();
      tick = 1'b0;
   endtask

   task automatic start_game();
      play_flag = 1'b1;
      step();
      m_lfsr = SEED_TB;
      m_run  = 1'b1;
   endtask

   initial begin
      Reset = 1'b1; play_flag = 1'b0; tick = 1'b0; gameover_in = 1'b0; occupied = 4'b0000;
      m_run = 1'b0;
      step();
      Reset = 1'b0;
      check("rst_spawn", 32'(spawn), 32'h0);
      check("rst_level", 32'(level), 32'h0);
      check("rst_count", 32'(spawn_count), 32'h0);
      check("rst_q_init", 32'(q_Init), 32'h1);
      check("rst_q_run", 32'(q_Run), 32'h0);
      check("rst_q_hold", 32'(q_Hold), 32'h0);

      // First game: free slots, tick every 10 cycles.
      start_game();
      check("run_entered", 32'(q_Run), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick_once();
         check("no_early_spawn", 32'(spawn), 32'h0);
      end
      tick_once();
      first_exp = exp_spawn;
      check("first_spawn", 32'(spawn), 32'(exp_spawn));
      check("first_count", 32'(spawn_count), 32'h1);
      step();
      check("pulse_width", 32'(spawn), 32'h0);

      occupied = 4'b0111;
      repeat (4) tick_once();
      check("only_right_free", 32'(spawn), 32'h8);
      check("count_2", 32'(spawn_count), 32'h2);

      // All busy through two attempts, then LEFT frees up.
      occupied = 4'b1111;
      repeat (4) tick_once();
      check("full_attempt1", 32'(spawn), 32'h0);
      repeat (4) tick_once();
      check("full_attempt2", 32'(spawn), 32'h0);
      check("full_count", 32'(spawn_count), 32'h2);
      occupied = 4'b1011;
      step();
      check("pending_spawn", 32'(spawn), 32'h4);
      check("pending_count", 32'(spawn_count), 32'h3);
      step();
      check("pending_single", 32'(spawn), 32'h0);
      check("pending_count_hold", 32'(spawn_count), 32'h3);

      // Level progression: 13 spawns at interval 4 reach 16.
      occupied = 4'b0000;
      run_ticks(52);
      check("count_16", 32'(spawn_count), 32'h10);
      check("level_lag", 32'(level), 32'h0);
      step();
      check("level_1", 32'(level), 32'h1);
      tick = 1'b1;
      step();
      check("l1_gap_a", 32'(spawn), 32'h0);
      step();
      check("l1_gap_b", 32'(spawn), 32'h0);
      step();
      check("l1_spawn_count", 32'(spawn_count), 32'h11);
      run_ticks(45);
      check("count_32", 32'(spawn_count), 32'h20);
      step();
      check("level_2", 32'(level), 32'h2);
      run_ticks(32);
      check("count_48", 32'(spawn_count), 32'h30);
      step();
      check("level_3", 32'(level), 32'h3);
      run_ticks(2);
      check("every_tick", 32'(spawn_count), 32'h32);

      play_flag = 1'b0;
      step();
      check("play_drop_ignored", 32'(q_Run), 32'h1);
      play_flag = 1'b1;
      run_ticks(210);
      check("count_saturate", 32'(spawn_count), 32'hFF);

      // Gameover coincident with an attempt.
      tick = 1'b1; gameover_in = 1'b1;
      step();
      m_run = 1'b0;
      tick = 1'b0; gameover_in = 1'b0;
      check("gameover_no_spawn", 32'(spawn), 32'h0);
      check("gameover_hold", 32'(q_Hold), 32'h1);
      check("gameover_count", 32'(spawn_count), 32'hFF);
      play_flag = 1'b0;
      step();
      check("back_to_init", 32'(q_Init), 32'h1);
      check("init_count_clear", 32'(spawn_count), 32'h0);
      step();
      check("init_level_clear", 32'(level), 32'h0);

      // Second game: get stuck pending, then reset mid-run.
      start_game();
      occupied = 4'b1111;
      repeat (4) tick_once();
      check("g2_pending", 32'(spawn), 32'h0);
      Reset = 1'b1; occupied = 4'b0000; play_flag = 1'b0;
      step();
      m_run = 1'b0;
      Reset = 1'b0;
      check("mid_rst_spawn", 32'(spawn), 32'h0);
      check("mid_rst_count", 32'(spawn_count), 32'h0);
      check("mid_rst_level", 32'(level), 32'h0);
      check("mid_rst_q_init", 32'(q_Init), 32'h1);
      check("mid_rst_q_run", 32'(q_Run), 32'h0);
      check("mid_rst_q_hold", 32'(q_Hold), 32'h0);
      step();
      check("no_spawn_after_rst", 32'(spawn), 32'h0);

      // Third game should reproduce the first game's opening slot.
      start_game();
      repeat (4) tick_once();
      check("repro_first_spawn", 32'(spawn), 32'(first_exp));
      check("repro_count", 32'(spawn_count), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
